// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg
// Shared definitions for the PE convolution sequencer: FSM state encoding,
// Avalon-MM register indices and the bit positions inside CTRL, STATUS and MODE.
package pe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_WRITE = 3'd5,
        ST_DRAIN = 3'd6
    } state_t;

    localparam logic [3:0] REG_CTRL     = 4'd0;
    localparam logic [3:0] REG_STATUS   = 4'd1;
    localparam logic [3:0] REG_CHANNELS = 4'd2;
    localparam logic [3:0] REG_OUT_ADDR = 4'd3;
    localparam logic [3:0] REG_IN_BASE  = 4'd4;
    localparam logic [3:0] REG_W_BASE   = 4'd5;
    localparam logic [3:0] REG_ROW_LEN  = 4'd6;
    localparam logic [3:0] REG_FILTER   = 4'd7;
    localparam logic [3:0] REG_MODE     = 4'd8;
    localparam logic [3:0] REG_CYCLES   = 4'd9;
    localparam logic [3:0] REG_STATE    = 4'd10;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_ABORT_BIT = 1;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_DONE_BIT  = 1;
    localparam int STATUS_ERROR_BIT = 2;

    localparam int MODE_RELU_BIT    = 0;
    localparam int MODE_POOL_BIT    = 1;
    localparam int MODE_OUTPUT_BIT  = 2;
    localparam int MODE_PARTIAL_BIT = 3;

endpackage

// File: rtl/pe_tap_addr_gen.sv
// pe_tap_addr_gen
// Tap counter and input/weight read pointers for one K x K x C filter window.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load              restart at tap 0 with pointers at the base addresses
//   step              advance to the next tap
//   k, c, l           filter size, channel count, row length
//   in_base, w_base   base addresses latched on load
//   in_ptr, w_ptr     current tap's read addresses
//   tap               current tap index
//   last_tap          current tap is K*K*C-1
module pe_tap_addr_gen #(
    parameter int ADDR_W    = 17,
    parameter int CNT_W     = 16,
    parameter int IN_STRIDE = 2,
    parameter int W_STRIDE  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [3:0]        k,
    input  logic [10:0]       c,
    input  logic [10:0]       l,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] w_base,
    output logic [ADDR_W-1:0] in_ptr,
    output logic [ADDR_W-1:0] w_ptr,
    output logic [CNT_W-1:0]  tap,
    output logic              last_tap
);

    // Products are formed at full width and only the address result truncated.
    localparam int PW = ADDR_W + CNT_W;

    logic [PW-1:0]     kc;
    logic [PW-1:0]     total;
    logic [ADDR_W-1:0] row_skip;
    logic [CNT_W-1:0]  col_reg;   // tap mod K*C, kept as a counter instead of a divider
    logic              row_end;

    assign kc       = PW'(k) * PW'(c);
    assign total    = kc * PW'(k);
    // Jump over the part of the input row the window does not cover.
    assign row_skip = ADDR_W'(PW'(IN_STRIDE) * (PW'(l) - PW'(k)) * PW'(c));
    assign row_end  = (PW'(col_reg) == kc - PW'(1));
    assign last_tap = (PW'(tap) == total - PW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap     <= '0;
            col_reg <= '0;
            in_ptr  <= '0;
            w_ptr   <= '0;
        end else if (load) begin
            tap     <= '0;
            col_reg <= '0;
            in_ptr  <= in_base;
            w_ptr   <= w_base;
        end else if (step && !last_tap) begin
            tap   <= tap + CNT_W'(1);
            w_ptr <= w_ptr + ADDR_W'(W_STRIDE);
            if (row_end) begin
                col_reg <= '0;
                in_ptr  <= in_ptr + ADDR_W'(IN_STRIDE) + row_skip;
            end else begin
                col_reg <= col_reg + CNT_W'(1);
                in_ptr  <= in_ptr + ADDR_W'(IN_STRIDE);
            end
        end
    end

endmodule

// File: rtl/pe_conv_sequencer.sv
// pe_conv_sequencer
// Run-time configurable convolution sequencer: Avalon-MM register file plus
// the FSM that walks the filter window, flushes, writes one output and drains.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   chipselect, write, address,
//   writedata, readdata          Avalon-MM slave (readdata registered, 1 cycle)
//   addr_input_pe/addr_weight_pe read addresses for the PE read masters
//   addr_write_pe                output write address (valid during WRITE)
//   *_master_en, pe_acc_clr      master enables and accumulator clear
//   relu_en..partial_en          MODE register bits
//   readdatavalid_input/_weight  read-master valids, only observed in INIT
module pe_conv_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 17,
    parameter int OUT_ADDR_W   = 15,
    parameter int CNT_W        = 16,
    parameter int IN_STRIDE    = 2,
    parameter int W_STRIDE     = 128,
    parameter int DRAIN_CYCLES = 64,
    parameter int MAX_K        = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic [3:0]            address,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [ADDR_W-1:0]     addr_input_pe,
    output logic [ADDR_W-1:0]     addr_weight_pe,
    output logic [OUT_ADDR_W-1:0] addr_write_pe,
    output logic                  input_master_en,
    output logic                  weight_master_en,
    output logic                  output_master_en,
    output logic                  pe_acc_clr,
    output logic                  relu_en,
    output logic                  pool_en,
    output logic                  output_en,
    output logic                  partial_en,
    input  logic                  readdatavalid_input,
    input  logic                  readdatavalid_weight
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t                state_reg;
    logic                  flush_reg;        // 0: first FLUSH cycle, 1: second
    logic [DW-1:0]         drain_cnt_reg;
    logic [CNT_W-1:0]      cycles_reg;
    logic                  done_reg;
    logic                  error_reg;
    logic [10:0]           channels_reg;
    logic [OUT_ADDR_W-1:0] out_addr_reg;
    logic [ADDR_W-1:0]     in_base_reg;
    logic [ADDR_W-1:0]     w_base_reg;
    logic [10:0]           row_len_reg;
    logic [3:0]            filter_reg;
    logic [3:0]            mode_reg;

    logic              wr, rd, busy, ctrl_wr, start_req, abort_req, cfg_ok, load, last_tap;
    logic [CNT_W-1:0]  tap;
    logic [ADDR_W-1:0] in_ptr, w_ptr;
    logic [31:0]       rd_mux;
    logic              unused_bits;

    assign unused_bits = ^writedata[31:ADDR_W];

    assign wr        = chipselect & write;
    assign rd        = chipselect & ~write;
    assign busy      = (state_reg != ST_IDLE);
    assign ctrl_wr   = wr && (address == REG_CTRL);
    // Abort takes priority over a start carried in the same write.
    assign abort_req = ctrl_wr && writedata[CTRL_ABORT_BIT];
    assign start_req = ctrl_wr && writedata[CTRL_START_BIT] && !writedata[CTRL_ABORT_BIT];
    assign cfg_ok    = (filter_reg != 4'd0) && (filter_reg <= 4'(MAX_K)) &&
                       (channels_reg != 11'd0) && (row_len_reg >= 11'(filter_reg));
    assign load      = start_req && !busy && cfg_ok;

    pe_tap_addr_gen #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .IN_STRIDE(IN_STRIDE), .W_STRIDE(W_STRIDE)
    ) u_tap_addr_gen (
        .clk(clk), .rst(rst), .load(load),
        .step(state_reg == ST_HOLD),
        .k(filter_reg), .c(channels_reg), .l(row_len_reg),
        .in_base(in_base_reg), .w_base(w_base_reg),
        .in_ptr(in_ptr), .w_ptr(w_ptr), .tap(tap), .last_tap(last_tap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            flush_reg     <= 1'b0;
            drain_cnt_reg <= '0;
            cycles_reg    <= '0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            if (busy && cycles_reg != '1)
                cycles_reg <= cycles_reg + CNT_W'(1);
            if (abort_req && busy) begin
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: if (start_req) begin
                        if (cfg_ok) begin
                            done_reg   <= 1'b0;
                            error_reg  <= 1'b0;
                            cycles_reg <= '0;
                            state_reg  <= ST_INIT;
                        end else begin
                            done_reg  <= 1'b1;
                            error_reg <= 1'b1;
                        end
                    end
                    ST_INIT: if (readdatavalid_input && readdatavalid_weight)
                        state_reg <= ST_ISSUE;
                    ST_ISSUE: state_reg <= ST_HOLD;
                    ST_HOLD: begin
                        flush_reg <= 1'b0;
                        state_reg <= last_tap ? ST_FLUSH : ST_ISSUE;
                    end
                    ST_FLUSH: begin
                        flush_reg <= 1'b1;
                        if (flush_reg) state_reg <= ST_WRITE;
                    end
                    ST_WRITE: begin
                        drain_cnt_reg <= '0;
                        state_reg     <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        if (drain_cnt_reg == DW'(DRAIN_CYCLES - 1)) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            drain_cnt_reg <= drain_cnt_reg + DW'(1);
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    // Configuration registers are frozen while a run is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            channels_reg <= '0;
            out_addr_reg <= '0;
            in_base_reg  <= '0;
            w_base_reg   <= '0;
            row_len_reg  <= '0;
            filter_reg   <= '0;
            mode_reg     <= '0;
            readdata     <= '0;
        end else begin
            if (wr && !busy) begin
                case (address)
                    REG_CHANNELS: channels_reg <= writedata[10:0];
                    REG_OUT_ADDR: out_addr_reg <= writedata[OUT_ADDR_W-1:0];
                    REG_IN_BASE:  in_base_reg  <= writedata[ADDR_W-1:0];
                    REG_W_BASE:   w_base_reg   <= writedata[ADDR_W-1:0];
                    REG_ROW_LEN:  row_len_reg  <= writedata[10:0];
                    REG_FILTER:   filter_reg   <= writedata[3:0];
                    REG_MODE:     mode_reg     <= writedata[3:0];
                    default: ;
                endcase
            end
            if (rd) readdata <= rd_mux;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            REG_STATUS: begin
                rd_mux[STATUS_BUSY_BIT]  = busy;
                rd_mux[STATUS_DONE_BIT]  = done_reg;
                rd_mux[STATUS_ERROR_BIT] = error_reg;
            end
            REG_CHANNELS: rd_mux[10:0]           = channels_reg;
            REG_OUT_ADDR: rd_mux[OUT_ADDR_W-1:0] = out_addr_reg;
            REG_IN_BASE:  rd_mux[ADDR_W-1:0]     = in_base_reg;
            REG_W_BASE:   rd_mux[ADDR_W-1:0]     = w_base_reg;
            REG_ROW_LEN:  rd_mux[10:0]           = row_len_reg;
            REG_FILTER:   rd_mux[3:0]            = filter_reg;
            REG_MODE:     rd_mux[3:0]            = mode_reg;
            REG_CYCLES:   rd_mux[CNT_W-1:0]      = cycles_reg;
            REG_STATE:    rd_mux[2:0]            = state_reg;
            default:      rd_mux                 = '0;
        endcase
    end

    // Outputs decode straight from the state so an asynchronous reset clears them at once.
    always_comb begin
        input_master_en  = 1'b0;
        weight_master_en = 1'b0;
        output_master_en = 1'b0;
        pe_acc_clr       = 1'b0;
        addr_write_pe    = '0;
        case (state_reg)
            ST_INIT, ST_HOLD: begin
                input_master_en  = 1'b1;
                weight_master_en = 1'b1;
            end
            ST_ISSUE: begin
                input_master_en  = 1'b1;
                weight_master_en = 1'b1;
                pe_acc_clr       = (tap == '0);
            end
            ST_FLUSH: weight_master_en = ~flush_reg;
            ST_WRITE: begin
                output_master_en = 1'b1;
                addr_write_pe    = out_addr_reg;
            end
            default: ;
        endcase
    end

    assign addr_input_pe  = in_ptr;
    assign addr_weight_pe = w_ptr;
    assign relu_en        = mode_reg[MODE_RELU_BIT];
    assign pool_en        = mode_reg[MODE_POOL_BIT];
    assign output_en      = mode_reg[MODE_OUTPUT_BIT];
    assign partial_en     = mode_reg[MODE_PARTIAL_BIT];

endmodule

// File: doc/pe_conv_sequencer.md
# pe_conv_sequencer

Parametrised convolution sequencer for the PE array. It is configured by the HPS over an Avalon-MM slave and walks a K×K×C filter window. For each tap it issues input and weight read addresses to the PE read masters, then issues one output write and a fixed drain period. It generalises the earlier fixed 3×3 controller to a run-time filter size, programmable base addresses and strides, sticky done/error status, and abort.

## Interface
Parameters:
- ADDR_W, 17, input/weight address width
- OUT_ADDR_W, 15, output write address width
- CNT_W, 16, tap/cycle counter width
- IN_STRIDE, 2, input words per tap
- W_STRIDE, 128, weight words per tap
- DRAIN_CYCLES, 64, wait after output write before done
- MAX_K, 7, largest legal filter size

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- chipselect, write  in  1  Avalon-MM slave strobes
- address  in  4  register index
- writedata  in  32  register write data
- readdata  out  32  registered read data, 1-cycle latency
- addr_input_pe  out  ADDR_W  input read address
- addr_weight_pe  out  ADDR_W  weight read address
- addr_write_pe  out  OUT_ADDR_W  output write address
- input_master_en, weight_master_en, output_master_en  out  1  master enables
- pe_acc_clr  out  1  PE accumulator clear
- relu_en, pool_en, output_en, partial_en  out  1  mode bits, from MODE register
- readdatavalid_input, readdatavalid_weight  in  1  read-master data valid

## Operation
- Registers: 0 CTRL (write-only; b0 start pulse, b1 abort pulse). 1 STATUS (b0 busy, b1 done sticky, b2 error sticky). 2 CHANNELS C[10:0]. 3 OUT_ADDR. 4 IN_BASE. 5 W_BASE. 6 ROW_LEN L[10:0]. 7 FILTER K[3:0]. 8 MODE (b0 relu, b1 pool, b2 output, b3 partial). 9 CYCLES (read-only). 10 STATE (read-only). Unused addresses read 0 and ignore writes.
- Writes to registers 2–8 while busy are ignored.
- States: IDLE, INIT, ISSUE, HOLD, FLUSH, WRITE, DRAIN.
- IDLE + start: clear done and error. If K==0, K>MAX_K, C==0 or L<K, set error and done, stay IDLE. Otherwise load tap=0, in_ptr=IN_BASE, w_ptr=W_BASE, CYCLES=0, go to INIT.
- INIT: drive in_ptr/w_ptr and both master enables. Go to ISSUE once readdatavalid_input and readdatavalid_weight are both high in the same cycle.
- ISSUE: drive addresses for the current tap with both enables high. Assert pe_acc_clr when tap==0. Then go to HOLD.
- HOLD: output_master_en=0. If tap==K·K·C−1, go to FLUSH. Otherwise tap++ and go to ISSUE.
- Pointer update per tap: w_ptr += W_STRIDE. in_ptr += IN_STRIDE, plus IN_STRIDE·(L−K)·C when (tap mod K·C)==K·C−1 and the tap is not the last.
- FLUSH: 2 cycles; input enable drops in cycle 1, weight enable in cycle 2.
- WRITE: addr_write_pe=OUT_ADDR, output_master_en=1 for exactly one cycle.
- DRAIN: count DRAIN_CYCLES, then set done, clear busy, go to IDLE.
- Arithmetic: evaluate all products at ADDR_W+CNT_W bits, truncate to ADDR_W; pointers wrap modulo 2^ADDR_W.
- CYCLES increments every non-IDLE cycle and saturates at all-ones.
- Abort in any non-IDLE state: next cycle IDLE, all enables 0, busy 0, done unchanged.
- Start while busy is ignored. Start and abort in the same write: abort wins.

## Timing
- Reset values: all enables, pe_acc_clr, mode bits, readdata = 0. Addresses = 0. conv registers = 0. State IDLE.
- Start write at cycle n: busy readable from cycle n+1, INIT at n+1.
- One tap per 2 cycles (ISSUE/HOLD). With the first valid pair at cycle v, the last tap's ISSUE is at cycle v+2·(K·K·C−1)+1.
- Both valids must be high in the same cycle to leave INIT; valids are ignored in all other states.
- Reset asserted mid-operation returns to reset values immediately (asynchronous).

## Structure
- Package pe_ctrl_pkg holds: state enum, register index constants, MODE/STATUS bit positions.
- Sub-module pe_tap_addr_gen holds tap counter, in_ptr/w_ptr and the row-skip arithmetic. Interface: load, step, last_tap out.
- Top level holds the register file and FSM.

## Test plan
- K=3, C=2, L=8, IN_BASE=0, W_BASE=0 → 18 taps. Input addresses 0,2..10,32..42,64..74; last weight address 2176; pe_acc_clr only on tap 0; one output write to OUT_ADDR.
- K=1, C=1 → one tap, FLUSH, WRITE, 64-cycle DRAIN; STATUS reads 0b010 afterwards.
- FILTER=0 or L=2 with K=3, then start → STATUS 0b110, no enable ever asserted.
- Abort written during tap 5 → IDLE next cycle, enables 0, busy 0, done 0.
- IN_BASE=0x1FFFE, C=1, K=2, L=2 → in_ptr wraps to 0x00000; CHANNELS write while busy leaves it unchanged.
- rst asserted mid-DRAIN → all outputs and readdata 0 without waiting for a clock edge.
